// File: rtl/alu_cmd_sequencer.sv
// Valid/ready command front-end for the 16-bit ALU: one command in flight, registered ALU drive, held response.
// Optional shift-and-add multiply (op 8) built from ALU ADD steps, enabled by macro ALU_SEQ_MUL_EN.
module alu_cmd_sequencer (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_CmdValid,
  output logic        o_CmdReady,
  input  logic [3:0]  i_CmdOp,
  input  logic [15:0] i_CmdA,
  input  logic [15:0] i_CmdB,
  output logic        o_RspValid,
  input  logic        i_RspReady,
  output logic [15:0] o_RspData,
  output logic        o_RspZero,
  output logic        o_RspErr,
  output logic [2:0]  o_ALUOp,
  output logic [15:0] o_ALUData0,
  output logic [15:0] o_ALUData1,
  input  logic [15:0] i_ALUResult,
  input  logic        i_ALUZero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
`ifdef ALU_SEQ_MUL_EN
    S_MUL,
`endif
    S_RESP
  } state_t;

  state_t      r_State;
  state_t      w_NextState;
  logic        w_Accept;
  logic        w_IsNative;
  logic [2:0]  r_ALUOp;
  logic [15:0] r_ALUData0;
  logic [15:0] r_ALUData1;
  logic [15:0] r_RspData;
  logic        r_RspZero;
  logic        r_RspErr;
`ifdef ALU_SEQ_MUL_EN
  logic        w_IsMul;
  logic [15:0] r_ASh;
  logic [15:0] r_BSh;
  logic [3:0]  r_MulCnt;

  assign w_IsMul = (i_CmdOp == 4'd8);
`endif

  assign o_CmdReady = (r_State == S_IDLE) & ~i_Reset;
  assign w_Accept   = i_CmdValid & o_CmdReady;
  assign w_IsNative = ~i_CmdOp[3];

  assign o_RspValid = (r_State == S_RESP);
  assign o_RspData  = r_RspData;
  assign o_RspZero  = r_RspZero;
  assign o_RspErr   = r_RspErr;
  assign o_ALUOp    = r_ALUOp;
  assign o_ALUData0 = r_ALUData0;
  assign o_ALUData1 = r_ALUData1;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_State <= S_IDLE;
    else         r_State <= w_NextState;
  end

  always_comb begin
    w_NextState = r_State;
    case (r_State)
      S_IDLE: begin
        if (w_Accept) begin
          if (w_IsNative) w_NextState = S_EXEC;
`ifdef ALU_SEQ_MUL_EN
          else if (w_IsMul) w_NextState = S_MUL;
`endif
          else w_NextState = S_RESP;
        end
      end
      S_EXEC: w_NextState = S_RESP;
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        if (r_MulCnt == 4'd15) w_NextState = S_RESP;
      end
`endif
      S_RESP: begin
        if (i_RspReady) w_NextState = S_IDLE;
      end
      default: w_NextState = S_IDLE;
    endcase
  end

  // In MUL, r_ALUData0 doubles as the accumulator; r_ASh/r_BSh already hold the next iteration's operands.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_ALUOp    <= 3'd0;
      r_ALUData0 <= 16'h0000;
      r_ALUData1 <= 16'h0000;
      r_RspData  <= 16'h0000;
      r_RspZero  <= 1'b0;
      r_RspErr   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_ASh      <= 16'h0000;
      r_BSh      <= 16'h0000;
      r_MulCnt   <= 4'd0;
`endif
    end else begin
      case (r_State)
        S_IDLE: begin
          if (w_Accept) begin
            if (w_IsNative) begin
              r_ALUOp    <= i_CmdOp[2:0];
              r_ALUData0 <= i_CmdA;
              r_ALUData1 <= i_CmdB;
            end
`ifdef ALU_SEQ_MUL_EN
            else if (w_IsMul) begin
              r_ALUOp    <= 3'd0;
              r_ALUData0 <= 16'h0000;
              r_ALUData1 <= i_CmdB[0] ? i_CmdA : 16'h0000;
              r_ASh      <= i_CmdA << 1;
              r_BSh      <= i_CmdB >> 1;
              r_MulCnt   <= 4'd0;
            end
`endif
            else begin
              r_RspData <= 16'h0000;
              r_RspZero <= 1'b1;
              r_RspErr  <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          r_RspData <= i_ALUResult;
          r_RspZero <= i_ALUZero;
          r_RspErr  <= 1'b0;
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          r_ALUData0 <= i_ALUResult;
          r_ALUData1 <= r_BSh[0] ? r_ASh : 16'h0000;
          r_ASh      <= r_ASh << 1;
          r_BSh      <= r_BSh >> 1;
          r_MulCnt   <= r_MulCnt + 4'd1;
          if (r_MulCnt == 4'd15) begin
            r_RspData <= i_ALUResult;
            r_RspZero <= i_ALUZero;
            r_RspErr  <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU fixture, scoreboard of expected responses, latency checks.
module tb_alu_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_vld, cmd_rdy;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        rsp_vld, rsp_rdy, rsp_zero, rsp_err;
  logic [15:0] rsp_dat;
  logic [2:0]  alu_op;
  logic [15:0] alu_d0, alu_d1, alu_res;
  logic        alu_zero;

  typedef struct packed {
    logic [15:0] dat;
    logic        zero;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   n_rsp = 0;

  logic [3:0]  t_op [0:9] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd1};
  logic [15:0] t_a  [0:9] = '{16'hF0F0, 16'hF000, 16'hAAAA, 16'h0001, 16'hFFFF,
                              16'h8000, 16'h1234, 16'h0001, 16'h8000, 16'h0000};
  logic [15:0] t_b  [0:9] = '{16'h3C3C, 16'h000F, 16'hAAAA, 16'h0004, 16'h0010,
                              16'h000F, 16'hFFFF, 16'h8000, 16'h0001, 16'h0001};

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_CmdValid  (cmd_vld),
    .o_CmdReady  (cmd_rdy),
    .i_CmdOp     (cmd_op),
    .i_CmdA      (cmd_a),
    .i_CmdB      (cmd_b),
    .o_RspValid  (rsp_vld),
    .i_RspReady  (rsp_rdy),
    .o_RspData   (rsp_dat),
    .o_RspZero   (rsp_zero),
    .o_RspErr    (rsp_err),
    .o_ALUOp     (alu_op),
    .o_ALUData0  (alu_d0),
    .o_ALUData1  (alu_d1),
    .i_ALUResult (alu_res),
    .i_ALUZero   (alu_zero)
  );

  // Combinational ALU the sequencer drives
  always_comb begin
    alu_res = 16'h0000;
    case (alu_op)
      3'd0: alu_res = alu_d0 + alu_d1;
      3'd1: alu_res = alu_d0 - alu_d1;
      3'd2: alu_res = alu_d0 & alu_d1;
      3'd3: alu_res = alu_d0 | alu_d1;
      3'd4: alu_res = alu_d0 ^ alu_d1;
      3'd5: alu_res = alu_d0 << alu_d1;
      3'd6: alu_res = alu_d0 >> alu_d1;
      3'd7: alu_res = {15'h0000, (alu_d0 < alu_d1)};
      default: ;
    endcase
  end
  assign alu_zero = (alu_res == 16'h0000);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    logic        e;
    d = 16'h0000;
    e = 1'b0;
    case (op)
      4'd0: d = a + b;
      4'd1: d = a - b;
      4'd2: d = a & b;
      4'd3: d = a | b;
      4'd4: d = a ^ b;
      4'd5: d = (b > 16'd15) ? 16'h0000 : (a << b[3:0]);
      4'd6: d = (b > 16'd15) ? 16'h0000 : (a >> b[3:0]);
      4'd7: d = (a < b) ? 16'h0001 : 16'h0000;
`ifdef ALU_SEQ_MUL_EN
      4'd8: d = a * b;
`endif
      default: e = 1'b1;
    endcase
    model = {d, (d == 16'h0000), e};
  endfunction

  always @(negedge clk) begin
    rsp_t e;
    if (!rst && rsp_vld && rsp_rdy) begin
      n_rsp++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_dat",  {16'h0, rsp_dat}, {16'h0, e.dat});
        chk("rsp_zero", {31'h0, rsp_zero}, {31'h0, e.zero});
        chk("rsp_err",  {31'h0, rsp_err},  {31'h0, e.err});
      end
    end
  end

  task automatic accept(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int waited);
    cmd_vld = 1'b1;
    cmd_op  = op;
    cmd_a   = a;
    cmd_b   = b;
    waited  = 0;
    while (!cmd_rdy && waited < 64) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cmd_rdy) chk("accept_timeout", 32'd0, 32'd1);
    else          sb.push_back(model(op, a, b));
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!rsp_vld && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(tag, lat, exp_lat);
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int lat, input string tag);
    int w;
    accept(op, a, b, w);
    cmd_vld = 1'b0;
    wait_rsp(tag, lat);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_rsp_vld",  {31'h0, rsp_vld},  32'd0);
    chk("rst_rsp_dat",  {16'h0, rsp_dat},  32'd0);
    chk("rst_rsp_zero", {31'h0, rsp_zero}, 32'd0);
    chk("rst_rsp_err",  {31'h0, rsp_err},  32'd0);
    chk("rst_alu_op",   {29'h0, alu_op},   32'd0);
    chk("rst_alu_d0",   {16'h0, alu_d0},   32'd0);
    chk("rst_alu_d1",   {16'h0, alu_d1},   32'd0);
    chk("rst_cmd_rdy",  {31'h0, cmd_rdy},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; cmd_vld = 1'b0; cmd_op = 4'd0; cmd_a = 16'h0; cmd_b = 16'h0; rsp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;
    #1;
    chk("rdy_after_reset", {31'h0, cmd_rdy}, 32'd1);

    // ADD with latency, ALU drive and ready-return checks
    accept(4'd0, 16'h1234, 16'h0001, w);
    cmd_vld = 1'b0;
    chk("add_alu_op", {29'h0, alu_op}, 32'd0);
    chk("add_alu_d0", {16'h0, alu_d0}, 32'h1234);
    chk("add_alu_d1", {16'h0, alu_d1}, 32'h0001);
    wait_rsp("lat_add", 2);
    chk("add_rdy_busy", {31'h0, cmd_rdy}, 32'd0);
    @(posedge clk); #1;
    chk("add_rdy_back", {31'h0, cmd_rdy}, 32'd1);
    chk("add_vld_drop", {31'h0, rsp_vld}, 32'd0);

    for (int i = 0; i < 10; i++) run_cmd(t_op[i], t_a[i], t_b[i], 2, "lat_native");

    // SUB held under back-pressure
    rsp_rdy = 1'b0;
    accept(4'd1, 16'h00FF, 16'h00FF, w);
    cmd_vld = 1'b0;
    wait_rsp("lat_sub", 2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld",  {31'h0, rsp_vld},  32'd1);
      chk("bp_dat",  {16'h0, rsp_dat},  32'd0);
      chk("bp_zero", {31'h0, rsp_zero}, 32'd1);
      chk("bp_err",  {31'h0, rsp_err},  32'd0);
      @(posedge clk); #1;
    end
    w = n_rsp;
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_vld_drop", {31'h0, rsp_vld}, 32'd0);
    chk("bp_one_rsp", n_rsp, w + 1);

    run_cmd(4'd12, 16'h5555, 16'h1111, 1, "lat_op12");
`ifdef ALU_SEQ_MUL_EN
    run_cmd(4'd8, 16'h0123, 16'h0045, 17, "lat_mul1");
    run_cmd(4'd8, 16'h8000, 16'h0002, 17, "lat_mul2");
    run_cmd(4'd8, 16'hFFFF, 16'hFFFF, 17, "lat_mul3");
    accept(4'd8, 16'h1111, 16'h0007, w);
    cmd_vld = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk_reset_state();
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mul_rst_no_rsp", {31'h0, rsp_vld}, 32'd0);
`else
    run_cmd(4'd8, 16'h0123, 16'h0045, 1, "lat_op8_off");
`endif

    // Reset while a response is being held
    rsp_rdy = 1'b0;
    accept(4'd0, 16'h0001, 16'h0001, w);
    cmd_vld = 1'b0;
    wait_rsp("lat_pre_rst", 2);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk_reset_state();
    rst = 1'b0;
    rsp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("resp_rst_no_rsp", {31'h0, rsp_vld}, 32'd0);
    w = n_rsp;
    run_cmd(4'd0, 16'h0002, 16'h0003, 2, "lat_add_after_rst");
    chk("add_after_rst_rsp", n_rsp, w + 1);

    // Back-to-back with valid held high
    accept(4'd0, 16'h0F0F, 16'h00F1, w);
    wait_rsp("lat_b2b1", 2);
    chk("b2b_rdy_busy", {31'h0, cmd_rdy}, 32'd0);
    accept(4'd2, 16'hF0F0, 16'h3C3C, w);
    chk("b2b_wait", w, 1);
    cmd_vld = 1'b0;
    wait_rsp("lat_b2b2", 2);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
